// File: rtl/systolic_skew_feeder.sv
// Edge driver for one side of the systolic MAC array: turns one operand vector
// per beat into the diagonal staircase (lane i delayed i cycles), with job control.
module systolic_skew_feeder #(
  parameter int N       = 4,
  parameter int IP_SIZE = 8,
  parameter int LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*IP_SIZE-1:0] in_data,
  output logic [N*IP_SIZE-1:0] lane_out,
  output logic [N-1:0]         lane_valid,
  output logic                 acc_clr,
  output logic                 busy,
  output logic                 done
);
  localparam int FW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [FW-1:0]    r_fc;
  logic             r_clr;
  logic             r_done;
  logic             w_acc;
  logic [LEN_W-1:0] w_cnt_nxt;

  assign in_ready  = (r_state == S_STREAM);
  assign busy      = (r_state != S_IDLE);
  assign acc_clr   = r_clr;
  assign done      = r_done;
  assign w_acc     = in_valid & in_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fc    <= '0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_clr  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_len   <= len;
              r_cnt   <= '0;
              r_clr   <= 1'b1;
              r_state <= S_STREAM;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (w_acc) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
              r_fc    <= '0;
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Leaving here lines done up with the cycle after lane N-1's last element.
          if (r_fc == FW'(N - 1)) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_fc <= r_fc + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane g: chain of g+1 stages; non-accepted cycles inject zeros so bubbles stay aligned.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [g:0][IP_SIZE-1:0] r_d;
    logic [g:0]              r_v;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_d <= '0;
        r_v <= '0;
      end else begin
        r_d[0] <= w_acc ? in_data[g*IP_SIZE +: IP_SIZE] : '0;
        r_v[0] <= w_acc;
        for (int s = 1; s <= g; s++) begin
          r_d[s] <= r_d[s-1];
          r_v[s] <= r_v[s-1];
        end
      end
    end

    assign lane_out[g*IP_SIZE +: IP_SIZE] = r_d[g];
    assign lane_valid[g]                  = r_v[g];
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed job scenarios plus random traffic,
// checked every cycle against a beat-history / job-level reference model.
module tb_systolic_skew_feeder;
  localparam int N       = 4;
  localparam int IP_SIZE = 8;
  localparam int LEN_W   = 16;
  localparam int HMAX    = 4096;

  logic                 clk = 1'b0;
  logic                 rst, start, in_valid;
  logic [LEN_W-1:0]     len;
  logic [N*IP_SIZE-1:0] in_data;
  logic                 in_ready, acc_clr, busy, done;
  logic [N*IP_SIZE-1:0] lane_out;
  logic [N-1:0]         lane_valid;

  systolic_skew_feeder #(.N(N), .IP_SIZE(IP_SIZE), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .lane_out(lane_out),
    .lane_valid(lane_valid), .acc_clr(acc_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Model: which edge accepted which vector, plus job-level bookkeeping.
  logic [N*IP_SIZE-1:0] hist_d [HMAX];
  bit                   hist_v [HMAX];
  int e        = 0;
  int last_rst = 0;
  int m_left   = 0;
  int m_drain  = 0;
  bit m_done   = 0;
  bit m_clr    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, e, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [LEN_W-1:0] l,
                      input bit v, input logic [N*IP_SIZE-1:0] d);
    bit                   acc;
    int                   src;
    logic [N*IP_SIZE-1:0] exp_out;
    logic [N-1:0]         exp_vld;
    rst = r; start = s; len = l; in_valid = v; in_data = d;
    acc = !r && (m_left > 0) && v;
    @(posedge clk);
    if (e < HMAX - 1) e++;
    hist_v[e] = acc;
    hist_d[e] = d;
    m_done = 0;
    m_clr  = 0;
    if (r) begin
      m_left = 0; m_drain = 0; last_rst = e;
    end else if (m_left == 0 && m_drain == 0) begin
      if (s) begin
        if (l != 0) begin m_left = int'(l); m_clr = 1; end
        else m_done = 1;
      end
    end else if (m_left > 0) begin
      if (acc) begin
        m_left--;
        if (m_left == 0) m_drain = N;
      end
    end else begin
      m_drain--;
      if (m_drain == 0) m_done = 1;
    end
    #1;
    exp_out = '0;
    exp_vld = '0;
    for (int i = 0; i < N; i++) begin
      src = e - i;
      if (src > last_rst && src >= 1 && hist_v[src]) begin
        exp_out[i*IP_SIZE +: IP_SIZE] = hist_d[src][i*IP_SIZE +: IP_SIZE];
        exp_vld[i] = 1'b1;
      end
    end
    chk("in_ready",   64'(in_ready),   64'(m_left > 0));
    chk("busy",       64'(busy),       64'(m_left > 0 || m_drain > 0));
    chk("acc_clr",    64'(acc_clr),    64'(m_clr));
    chk("done",       64'(done),       64'(m_done));
    chk("lane_out",   64'(lane_out),   64'(exp_out));
    chk("lane_valid", 64'(lane_valid), 64'(exp_vld));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, '0);
  endtask

  initial begin
    for (int k = 0; k < HMAX; k++) begin hist_v[k] = 0; hist_d[k] = '0; end
    // Reset held with random inputs.
    for (int k = 0; k < 3; k++)
      step(1, 1'($urandom), LEN_W'($urandom), 1'($urandom), ($urandom));
    idle(2);

    // Basic skew, len=3, beats from the acc_clr cycle.
    step(0, 1, 16'd3, 0, '0);
    step(0, 0, '0, 1, 32'h04030201);
    step(0, 0, '0, 1, 32'h08070605);
    step(0, 0, '0, 1, 32'h0C0B0A09);
    idle(7);

    // Bubbles, len=2.
    step(0, 1, 16'd2, 0, '0);
    step(0, 0, '0, 1, 32'h11111111);
    step(0, 0, '0, 0, 32'hDEADBEEF);
    step(0, 0, '0, 0, 32'hDEADBEEF);
    step(0, 0, '0, 1, 32'h22222222);
    idle(7);

    // len=0 start.
    step(0, 1, 16'd0, 1, 32'h55555555);
    idle(3);

    // start while busy is ignored; extra offered beats are not taken.
    step(0, 1, 16'd2, 0, '0);
    step(0, 0, '0, 1, 32'hA1A2A3A4);
    step(0, 1, 16'd5, 0, '0);
    step(0, 0, '0, 1, 32'hB1B2B3B4);
    for (int k = 0; k < 4; k++) step(0, 1'(k == 1), 16'd5, 1, 32'hC0C0C0C0);
    idle(6);

    // rst after 2 of 4 beats, then a len=1 job.
    step(0, 1, 16'd4, 0, '0);
    step(0, 0, '0, 1, 32'h31323334);
    step(0, 0, '0, 1, 32'h41424344);
    step(1, 0, '0, 1, 32'h51525354);
    idle(2);
    step(0, 1, 16'd1, 0, '0);
    step(0, 0, '0, 1, 32'h61626364);
    idle(6);

    // Random traffic: random starts, lengths, bubbles and data.
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) == 0),
           LEN_W'($urandom_range(0, 6)), 1'($urandom_range(0, 2) != 0), $urandom);
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
